// File: rtl/wb_pkg.sv
// Shared writeback types: the LSU FIFO entry layout and architectural register count.
package wb_pkg;

  localparam int REG_COUNT = 32;
  localparam int RD_W      = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] value;
  } wb_entry_t;

  // The register file takes a 6-bit index whose top bit is always clear.
  function automatic logic [RD_W:0] to_rf_index(input logic [RD_W-1:0] idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular-buffer FIFO with wrapping read/write pointers and an occupancy counter.
module wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 37,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; nothing is read beyond count, so clearing the pointers suffices.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered LSU results onto the single register-file write port.
// Optional destination scoreboard enabled by defining WB_SCOREBOARD_EN.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter  int s     = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [s-1:0]  alu_value,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [4:0]    lsu_rd,
  input  logic [s-1:0]  lsu_value,
  input  logic          issue_long,
  input  logic [4:0]    issue_rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic [5:0]    rd,
  output logic          register_write,
  output logic [s-1:0]  rd_value,
  output logic [CW-1:0] fifo_count
);

  wb_entry_t push_entry;
  wb_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      push;
  logic      pop;
  logic      alu_wins;
  logic [4:0] rd_q;

  // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign lsu_ready  = !reset && !fifo_full;
  assign push       = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign push_entry = '{rd: lsu_rd, value: lsu_value};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    // NOTE: defaults come first so no path leaves a combinational signal unassigned (no latches).
    alu_wins = 1'b0;
    pop      = 1'b0;
    if (!reset) begin
      if (alu_valid && (alu_rd != '0)) alu_wins = 1'b1;
      else if (!fifo_empty)            pop      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      register_write <= 1'b0;
      rd_q           <= '0;
      rd_value       <= '0;
    end else if (alu_wins) begin
      register_write <= 1'b1;
      rd_q           <= alu_rd;
      rd_value       <= alu_value;
    end else if (pop) begin
      register_write <= 1'b1;
      rd_q           <= head.rd;
      rd_value       <= head.value;
    end else begin
      register_write <= 1'b0;
    end
  end

  assign rd = to_rf_index(rd_q);

`ifdef WB_SCOREBOARD_EN
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] clr_mask;

  // Clear lands on the pop edge, so the bit drops in the cycle the write shows on the port.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_long) set_mask[issue_rd] = 1'b1;
    if (pop)        clr_mask[head.rd]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~REG_COUNT'(1);
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{issue_long, issue_rd, rs1, rs2};
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: vector table, directed sequences, randomized model check.
module tb_writeback_arbiter;

  localparam int S     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [S-1:0]  alu_value;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic [S-1:0]  lsu_value;
  logic          issue_long;
  logic [4:0]    issue_rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic          rs1_busy;
  logic          rs2_busy;
  logic [5:0]    rd;
  logic          register_write;
  logic [S-1:0]  rd_value;
  logic [CW-1:0] fifo_count;

  writeback_arbiter #(.s(S), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_value      (alu_value),
    .lsu_valid      (lsu_valid),
    .lsu_ready      (lsu_ready),
    .lsu_rd         (lsu_rd),
    .lsu_value      (lsu_value),
    .issue_long     (issue_long),
    .issue_rd       (issue_rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .rd             (rd),
    .register_write (register_write),
    .rd_value       (rd_value),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending LSU writes and a plain busy array.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
  } ent_t;

  ent_t        mq[$];
  bit          mbusy[32];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_val;

  task automatic model_edge();
    int   sz;
    ent_t e;
    sz = mq.size();
    if (reset) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_we  = 1'b0;
      m_rd  = '0;
      m_val = '0;
      return;
    end
    if (alu_valid && alu_rd != 0) begin
      m_we = 1'b1; m_rd = alu_rd; m_val = alu_value;
    end else if (sz > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_val = e.value;
      mbusy[e.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (lsu_valid && sz < DEPTH && lsu_rd != 0) mq.push_back('{lsu_rd, lsu_value});
    if (issue_long && issue_rd != 0) mbusy[issue_rd] = 1'b1;
  endtask

  task automatic model_check();
    check("rnd.register_write", register_write, m_we);
    if (m_we) begin
      check("rnd.rd", rd, {1'b0, m_rd});
      check("rnd.rd_value", rd_value, m_val);
    end
    check("rnd.fifo_count", fifo_count, mq.size());
    check("rnd.lsu_ready", lsu_ready, (!reset && mq.size() < DEPTH));
    check("rnd.rs1_busy", rs1_busy, SB && mbusy[rs1]);
    check("rnd.rs2_busy", rs2_busy, SB && mbusy[rs2]);
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = 0; alu_value = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_value = 0;
    issue_long = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic finish_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          av;  logic [4:0] ar; logic [31:0] aval;
    bit          lv;  logic [4:0] lr; logic [31:0] lval;
    bit          we;  logic [5:0] rd; logic [31:0] val;
    int          cnt; bit rdy;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // Expected outputs are those visible during the cycle the row's inputs are applied.
    tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 0,          0, 0,  0,            0, 1};
    tbl[1]  = '{0, 0,  0,            0, 0, 0,          1, 5,  32'hDEADBEEF, 0, 1};
    tbl[2]  = '{0, 0,  0,            0, 0, 0,          0, 0,  0,            0, 1};
    tbl[3]  = '{1, 10, 32'hA0,       1, 1, 32'h101,    0, 0,  0,            0, 1};
    tbl[4]  = '{1, 11, 32'hA1,       1, 2, 32'h102,    1, 10, 32'hA0,       1, 1};
    tbl[5]  = '{1, 12, 32'hA2,       1, 3, 32'h103,    1, 11, 32'hA1,       2, 1};
    tbl[6]  = '{1, 13, 32'hA3,       1, 4, 32'h104,    1, 12, 32'hA2,       3, 1};
    tbl[7]  = '{1, 14, 32'hA4,       1, 9, 32'h109,    1, 13, 32'hA3,       4, 0};
    tbl[8]  = '{1, 15, 32'hA5,       0, 0, 0,          1, 14, 32'hA4,       4, 0};
    tbl[9]  = '{0, 0,  0,            0, 0, 0,          1, 15, 32'hA5,       4, 0};
    tbl[10] = '{0, 0,  0,            0, 0, 0,          1, 1,  32'h101,      3, 1};
    tbl[11] = '{0, 0,  0,            0, 0, 0,          1, 2,  32'h102,      2, 1};
    tbl[12] = '{0, 0,  0,            0, 0, 0,          1, 3,  32'h103,      1, 1};
    tbl[13] = '{0, 0,  0,            0, 0, 0,          1, 4,  32'h104,      0, 1};
    tbl[14] = '{0, 0,  0,            0, 0, 0,          0, 0,  0,            0, 1};
    tbl[15] = '{0, 0,  0,            1, 6, 32'h66,     0, 0,  0,            0, 1};
    tbl[16] = '{1, 0,  32'hBAD,      1, 0, 32'hBAD0,   0, 0,  0,            1, 1};
    tbl[17] = '{0, 0,  0,            0, 0, 0,          1, 6,  32'h66,       0, 1};
    tbl[18] = '{0, 0,  0,            0, 0, 0,          0, 0,  0,            0, 1};

    set_idle();
    reset = 1;
    @(negedge clk);
    check("init.lsu_ready_in_reset", lsu_ready, 0);
    finish_cycle();
    reset = 0;
    @(negedge clk);
    check("init.register_write", register_write, 0);
    check("init.rd", rd, 0);
    check("init.rd_value", rd_value, 0);
    check("init.fifo_count", fifo_count, 0);
    check("init.lsu_ready", lsu_ready, 1);
    check("init.rs1_busy", rs1_busy, 0);
    finish_cycle();

    for (int i = 0; i < NV; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ar; alu_value = tbl[i].aval;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lr; lsu_value = tbl[i].lval;
      @(negedge clk);
      check($sformatf("vec%0d.register_write", i), register_write, tbl[i].we);
      if (tbl[i].we) begin
        check($sformatf("vec%0d.rd", i), rd, tbl[i].rd);
        check($sformatf("vec%0d.rd_value", i), rd_value, tbl[i].val);
      end
      check($sformatf("vec%0d.fifo_count", i), fifo_count, tbl[i].cnt);
      check($sformatf("vec%0d.lsu_ready", i), lsu_ready, tbl[i].rdy);
      finish_cycle();
    end
    set_idle();

    // Scoreboard: set, hold, clear on drain, then set-wins on a same-cycle reissue.
    rs1 = 7; rs2 = 7; issue_long = 1; issue_rd = 7;
    @(negedge clk); check("sb.before_set", rs1_busy, 0); finish_cycle();
    issue_long = 0;
    @(negedge clk); check("sb.set_rs1", rs1_busy, SB); finish_cycle();
    lsu_valid = 1; lsu_rd = 7; lsu_value = 32'h77;
    @(negedge clk); check("sb.set_rs2", rs2_busy, SB); finish_cycle();
    lsu_valid = 0;
    @(negedge clk); check("sb.held_queued", rs1_busy, SB); check("sb.count", fifo_count, 1); finish_cycle();
    @(negedge clk);
    check("sb.drain_we", register_write, 1);
    check("sb.drain_rd", rd, 7);
    check("sb.cleared", rs1_busy, 0);
    finish_cycle();
    issue_long = 1;
    @(negedge clk); finish_cycle();
    issue_long = 0; lsu_valid = 1; lsu_value = 32'h78;
    @(negedge clk); check("sb.reset_again", rs1_busy, SB); finish_cycle();
    lsu_valid = 0; issue_long = 1;
    @(negedge clk); check("sb.before_clash", rs1_busy, SB); finish_cycle();
    issue_long = 0;
    @(negedge clk);
    check("sb.clash_value", rd_value, 32'h78);
    check("sb.set_wins", rs1_busy, SB);
    finish_cycle();
    lsu_valid = 1; lsu_value = 32'h79;
    @(negedge clk); finish_cycle();
    lsu_valid = 0;
    @(negedge clk); finish_cycle();
    @(negedge clk);
    check("sb.final_value", rd_value, 32'h79);
    check("sb.final_clear", rs1_busy, 0);
    finish_cycle();
    set_idle();

    // Mid-operation reset with three queued entries and a busy register.
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1; alu_rd = 20; alu_value = 32'h20;
      lsu_valid = 1; lsu_rd = 5'(i); lsu_value = 32'(i);
      issue_long = (i == 1); issue_rd = 9; rs1 = 9;
      @(negedge clk); finish_cycle();
    end
    reset = 1; issue_long = 0; lsu_rd = 4;
    @(negedge clk);
    check("rst.lsu_ready_low", lsu_ready, 0);
    check("rst.count_before", fifo_count, 3);
    check("rst.busy_before", rs1_busy, SB);
    finish_cycle();
    reset = 0; set_idle(); rs1 = 9;
    @(negedge clk);
    check("rst.count", fifo_count, 0);
    check("rst.register_write", register_write, 0);
    check("rst.rd", rd, 0);
    check("rst.rd_value", rd_value, 0);
    check("rst.busy", rs1_busy, 0);
    check("rst.lsu_ready_after", lsu_ready, 1);
    finish_cycle();
    @(negedge clk);
    check("rst.no_drain", register_write, 0);
    finish_cycle();

    // Randomized traffic against the reference model.
    reset = 1;
    @(negedge clk); finish_cycle();
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      alu_valid  = ($urandom_range(0, 99) < 55);
      alu_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_value  = $urandom;
      lsu_valid  = ($urandom_range(0, 99) < 60);
      lsu_rd     = 5'($urandom_range(0, 7));
      lsu_value  = $urandom;
      issue_long = ($urandom_range(0, 3) == 0);
      issue_rd   = 5'($urandom_range(0, 7));
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom);
      @(negedge clk);
      model_check();
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
